// File: rtl/env_voice_sched_pkg.sv
// Shared types and helpers for the time-multiplexed envelope scheduler.
package env_pkg;

  localparam int NUM_VOICES_DEF = 3;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_ATTACK  = 2'b01,
    PH_DECAY   = 2'b10,
    PH_SUSTAIN = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'b00,
    SWEEP      = 2'b01,
    DONE       = 2'b10
  } sched_e;

  // Ticks per level step for a 4-bit rate code.
  function automatic logic [15:0] rate_period(input logic [3:0] r);
    return 16'd1 << r;
  endfunction

  // Sustain nibble replicated into a full 8-bit level.
  function automatic logic [7:0] sustain_level(input logic [3:0] s);
    return {s, s};
  endfunction

endpackage

// File: rtl/env_voice_sched_if.sv
// Control/volume bundle between the voice register block and the scheduler.
interface env_voice_sched_if
  import env_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF
);
  logic                    tick;
  logic [NUM_VOICES-1:0]   gate;
  logic [16*NUM_VOICES-1:0] adsr;
  logic [8*NUM_VOICES-1:0] vol_out;
  logic                    vol_valid;
  logic                    busy;
  logic                    overrun;

  modport master (output tick, gate, adsr, input vol_out, vol_valid, busy, overrun);
  modport slave  (input tick, gate, adsr, output vol_out, vol_valid, busy, overrun);
endinterface

// File: rtl/env_voice_sched_step.sv
// Single-voice ADSR next-state; shared by all voices through the slot mux.
module env_step
  import env_pkg::*;
#(
  parameter int RATE_W = 16
) (
  input  phase_e            phase_i,
  input  logic [7:0]        level_i,
  input  logic [RATE_W-1:0] cnt_i,
  input  logic              prev_gate_i,
  input  logic              gate_i,
  input  logic [15:0]       adsr_i,
  output phase_e            phase_o,
  output logic [7:0]        level_o,
  output logic [RATE_W-1:0] cnt_o
);

  logic [3:0]  rate;
  logic [7:0]  sl;
  logic [7:0]  level_dec;
  logic [15:0] period_m1;
  logic        tc;

  // Gate edges take priority; otherwise advance the current phase by one slot.
  always_comb begin
    phase_o   = phase_i;
    level_o   = level_i;
    cnt_o     = cnt_i;
    sl        = sustain_level(adsr_i[7:4]);
    level_dec = level_i - 8'd1;
    case (phase_i)
      PH_ATTACK: rate = adsr_i[15:12];
      PH_DECAY:  rate = adsr_i[11:8];
      default:   rate = adsr_i[3:0];
    endcase
    period_m1 = rate_period(rate) - 16'd1;
    // >= so a rate shortened mid-count steps at once instead of wrapping.
    tc = (cnt_i >= RATE_W'(period_m1));

    if (gate_i && !prev_gate_i) begin
      phase_o = PH_ATTACK;
      cnt_o   = '0;
    end else if (!gate_i && prev_gate_i) begin
      phase_o = PH_IDLE;
      cnt_o   = '0;
    end else begin
      case (phase_i)
        PH_ATTACK: begin
          if (level_i == 8'hFF) begin
            phase_o = PH_DECAY;
            cnt_o   = '0;
          end else if (tc) begin
            level_o = level_i + 8'd1;
            cnt_o   = '0;
            if (level_i == 8'hFE) phase_o = PH_DECAY;
          end else begin
            cnt_o = cnt_i + RATE_W'(1);
          end
        end
        PH_DECAY: begin
          if (level_i <= sl) begin
            phase_o = PH_SUSTAIN;
          end else if (tc) begin
            level_o = level_dec;
            cnt_o   = '0;
            if (level_dec <= sl) phase_o = PH_SUSTAIN;
          end else begin
            cnt_o = cnt_i + RATE_W'(1);
          end
        end
        PH_SUSTAIN: begin
          if (level_i > sl) begin
            phase_o = PH_DECAY;
            cnt_o   = '0;
          end
        end
        default: begin
          if (level_i == 8'h00) begin
            cnt_o = '0;
          end else if (tc) begin
            level_o = level_dec;
            cnt_o   = '0;
          end else begin
            cnt_o = cnt_i + RATE_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/env_voice_sched.sv
// Round-robin envelope scheduler: one env_step serves every voice per tick.
//
//   state      | meaning
//   SCHED_IDLE | waiting for tick
//   SWEEP      | servicing voice slot_q, one voice per cycle
//   DONE       | all bytes final, vol_valid pulses
module env_voice_sched
  import env_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int RATE_W     = 16
) (
  input logic               clk,
  input logic               rst,
  env_voice_sched_if.slave  bus
);

  localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

  sched_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                overrun_q, overrun_d;
  phase_e              phase_q [NUM_VOICES];
  phase_e              phase_d [NUM_VOICES];
  logic [7:0]          level_q [NUM_VOICES];
  logic [7:0]          level_d [NUM_VOICES];
  logic [RATE_W-1:0]   cnt_q   [NUM_VOICES];
  logic [RATE_W-1:0]   cnt_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] pgate_q, pgate_d;

  phase_e            cur_phase, nxt_phase;
  logic [7:0]        cur_level, nxt_level;
  logic [RATE_W-1:0] cur_cnt, nxt_cnt;
  logic              cur_pgate, cur_gate;
  logic [15:0]       cur_adsr;

  // Present the serviced voice's state and controls to the shared step logic.
  always_comb begin
    cur_phase = phase_q[slot_q];
    cur_level = level_q[slot_q];
    cur_cnt   = cnt_q[slot_q];
    cur_pgate = pgate_q[slot_q];
    cur_gate  = bus.gate[slot_q];
    cur_adsr  = bus.adsr[16*slot_q +: 16];
  end

  env_step #(.RATE_W(RATE_W)) u_step (
    .phase_i     (cur_phase),
    .level_i     (cur_level),
    .cnt_i       (cur_cnt),
    .prev_gate_i (cur_pgate),
    .gate_i      (cur_gate),
    .adsr_i      (cur_adsr),
    .phase_o     (nxt_phase),
    .level_o     (nxt_level),
    .cnt_o       (nxt_cnt)
  );

  // Sweep sequencing and write-back of the serviced voice.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    overrun_d = overrun_q;
    phase_d   = phase_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    pgate_d   = pgate_q;
    case (state_q)
      SCHED_IDLE: begin
        if (bus.tick) begin
          state_d = SWEEP;
          slot_d  = '0;
        end
      end
      SWEEP: begin
        phase_d[slot_q] = nxt_phase;
        level_d[slot_q] = nxt_level;
        cnt_d[slot_q]   = nxt_cnt;
        pgate_d[slot_q] = cur_gate;
        if (bus.tick) overrun_d = 1'b1;
        if (slot_q == LAST_SLOT) state_d = DONE;
        else                     slot_d  = slot_q + 1'b1;
      end
      DONE: begin
        if (bus.tick) overrun_d = 1'b1;
        state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // State registers; reset abandons any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCHED_IDLE;
      slot_q    <= '0;
      overrun_q <= 1'b0;
      pgate_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= PH_IDLE;
        level_q[v] <= '0;
        cnt_q[v]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      overrun_q <= overrun_d;
      pgate_q   <= pgate_d;
      phase_q   <= phase_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy      = (state_q == SWEEP);
  assign bus.vol_valid = (state_q == DONE);
  assign bus.overrun   = overrun_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_vol
    assign bus.vol_out[8*v +: 8] = level_q[v];
  end

endmodule

// File: tb/tb_env_voice_sched.sv
// Bench for env_voice_sched: vector table through a scoreboard plus timing sequences.
module tb_env_voice_sched;

  typedef struct {
    bit          do_rst;
    logic [2:0]  gate;
    logic [47:0] adsr;
    int          nticks;
    logic [23:0] exp_vol;
  } vec_t;

  typedef struct {
    int          id;
    logic [23:0] vol;
  } sb_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  vec_t vecs[$];
  sb_t  sb[$];

  env_voice_sched_if bus ();

  env_voice_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic void add(input bit r, input logic [2:0] g, input logic [47:0] a,
                              input int n, input logic [23:0] e);
    vecs.push_back('{r, g, a, n, e});
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Drive one tick, then pop the scoreboard when vol_valid arrives.
  task automatic send_tick(input bit chk_en, input logic [23:0] exp, input int id);
    bit  seen;
    sb_t e;
    if (chk_en) sb.push_back('{id, exp});
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.vol_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL vol_valid_timeout vec %0d: no pulse in 8 cycles, required one", id);
      if (sb.size() > 0) e = sb.pop_front();
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (bus.vol_out !== e.vol) begin
        n_fail++;
        $display("FAIL vol vec %0d: got %h, required %h", e.id, bus.vol_out, e.vol);
      end
    end
  endtask

  initial begin
    bit saw_vv;
    clk = 1'b0;
    rst = 1'b1;
    n_vec = 0;
    n_fail = 0;
    bus.tick = 1'b0;
    bus.gate = '0;
    bus.adsr = '0;
    repeat (3) @(negedge clk);

    do_reset();
    @(negedge clk);
    chk("rst_vol", 32'(bus.vol_out), 32'h0);
    chk("rst_busy_tick_ignored", 32'(bus.busy), 32'h0);
    chk("rst_vol_valid", 32'(bus.vol_valid), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);

    // Full envelope on voice 0: A=0 D=0 S=8 R=0
    add(1, 3'b001, 48'h0000_0000_0080, 1,   24'h000000);
    add(0, 3'b001, 48'h0000_0000_0080, 1,   24'h000001);
    add(0, 3'b001, 48'h0000_0000_0080, 254, 24'h0000FF);
    add(0, 3'b001, 48'h0000_0000_0080, 1,   24'h0000FE);
    add(0, 3'b001, 48'h0000_0000_0080, 118, 24'h000088);
    add(0, 3'b001, 48'h0000_0000_0080, 50,  24'h000088);
    add(0, 3'b000, 48'h0000_0000_0080, 1,   24'h000088);
    add(0, 3'b000, 48'h0000_0000_0080, 1,   24'h000087);
    add(0, 3'b000, 48'h0000_0000_0080, 134, 24'h000001);
    add(0, 3'b000, 48'h0000_0000_0080, 1,   24'h000000);
    add(0, 3'b000, 48'h0000_0000_0080, 5,   24'h000000);
    // Decay entry already at SL, then S lowered while sustaining
    add(1, 3'b001, 48'h0000_0000_00F0, 256, 24'h0000FF);
    add(0, 3'b001, 48'h0000_0000_00F0, 1,   24'h0000FF);
    add(0, 3'b001, 48'h0000_0000_00F0, 3,   24'h0000FF);
    add(0, 3'b001, 48'h0000_0000_00E0, 1,   24'h0000FF);
    add(0, 3'b001, 48'h0000_0000_00E0, 1,   24'h0000FE);
    add(0, 3'b001, 48'h0000_0000_00E0, 16,  24'h0000EE);
    add(0, 3'b001, 48'h0000_0000_00E0, 5,   24'h0000EE);
    // Rate scaling: A=2 -> one step every 4 ticks
    add(1, 3'b001, 48'h0000_0000_2000, 4,   24'h000000);
    add(0, 3'b001, 48'h0000_0000_2000, 1,   24'h000001);
    add(0, 3'b001, 48'h0000_0000_2000, 3,   24'h000001);
    add(0, 3'b001, 48'h0000_0000_2000, 1,   24'h000002);
    // Independence: A=0/1/3, voice 1 gate toggled
    add(1, 3'b111, 48'h3000_1000_0000, 17,  24'h020810);
    add(0, 3'b101, 48'h3000_1000_0000, 1,   24'h020811);
    add(0, 3'b111, 48'h3000_1000_0000, 1,   24'h020812);
    add(0, 3'b111, 48'h3000_1000_0000, 4,   24'h020A16);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      @(negedge clk);
      bus.gate = vecs[i].gate;
      bus.adsr = vecs[i].adsr;
      for (int k = 1; k <= vecs[i].nticks; k++)
        send_tick(k == vecs[i].nticks, vecs[i].exp_vol, i);
    end

    // Sweep timing: per-byte write-back, busy window, vol_valid pulse
    do_reset();
    @(negedge clk);
    bus.gate = 3'b111;
    bus.adsr = '0;
    send_tick(1'b0, 24'h0, 50);
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_valid", 32'(bus.vol_valid), 32'h0);
    chk("t1_vol", 32'(bus.vol_out), 32'h000000);
    @(negedge clk);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    chk("t2_vol", 32'(bus.vol_out), 32'h000001);
    @(negedge clk);
    chk("t3_busy", 32'(bus.busy), 32'h1);
    chk("t3_vol", 32'(bus.vol_out), 32'h000101);
    @(negedge clk);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    chk("t4_valid", 32'(bus.vol_valid), 32'h1);
    chk("t4_vol", 32'(bus.vol_out), 32'h010101);
    // tick landing in DONE is dropped and flagged
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("t5_valid", 32'(bus.vol_valid), 32'h0);
    chk("done_tick_busy", 32'(bus.busy), 32'h0);
    chk("done_tick_overrun", 32'(bus.overrun), 32'h1);

    // Overrun: second tick two cycles into a sweep
    do_reset();
    @(negedge clk);
    bus.gate = 3'b001;
    bus.adsr = '0;
    send_tick(1'b0, 24'h0, 60);
    chk("ovr_clear", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    saw_vv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.vol_valid) begin
        saw_vv = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ovr_valid_seen", 32'(saw_vv), 32'h1);
    chk("ovr_vol_once", 32'(bus.vol_out), 32'h000001);
    chk("ovr_set", 32'(bus.overrun), 32'h1);
    @(negedge clk);
    chk("ovr_no_resweep", 32'(bus.busy), 32'h0);
    send_tick(1'b1, 24'h000002, 61);
    chk("ovr_sticky", 32'(bus.overrun), 32'h1);

    // Reset mid-sweep
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_vol", 32'(bus.vol_out), 32'h0);
    chk("rmid_busy", 32'(bus.busy), 32'h0);
    chk("rmid_valid", 32'(bus.vol_valid), 32'h0);
    chk("rmid_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    bus.gate = 3'b000;
    saw_vv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.vol_valid) saw_vv = 1'b1;
    end
    chk("rmid_no_valid", 32'(saw_vv), 32'h0);
    send_tick(1'b1, 24'h000000, 70);
    @(negedge clk);
    bus.gate = 3'b001;
    send_tick(1'b1, 24'h000000, 71);
    send_tick(1'b1, 24'h000001, 72);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
